ir_loader_dma: RTL and testbench
================================

// Module: ir_loader_dma
// PURPOSE
//  Parametrised instruction loader. Fetches a 3-word descriptor (src, dst, count),
//  then copies count words from instruction cache to IR register file, one word
//  per read/write pair, with write backpressure, abort and a done pulse.
//  Sits between the IR decoder (start) and the cache / IR regfile ports.
// PARAMETERS
//  DATA_WIDTH  8     width of cache data, IR regfile data and descriptor words
//  ADDR_WIDTH  8     cache and IR regfile address width (src/dst = low ADDR_WIDTH bits)
//  CNT_WIDTH   8     transfer-count width (count = low CNT_WIDTH bits of word 2)
//  RD_LAT      1     cache read latency in cycles, >=1
//  INIT_LINES  8'hFF word count for the init preload (IRL_INIT_EN only)
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           synchronous active-low reset
//  i_start       in   1           start descriptor fetch; sampled in IDLE only
//  i_init        in   1           init preload request (IRL_INIT_EN only)
//  i_abort       in   1           abort current operation
//  i_param_data  in   DATA_WIDTH  descriptor word, valid while o_param_req=1
//  o_param_req   out  1           descriptor word read strobe
//  o_cash_ren    out  1           cache read enable, 1-cycle pulse
//  o_cash_addr   out  ADDR_WIDTH  cache read address
//  i_cash_data   in   DATA_WIDTH  cache data, valid RD_LAT cycles after o_cash_ren
//  o_ir_wen      out  1           IR regfile write request, held until i_ir_ready
//  o_ir_addr     out  ADDR_WIDTH  IR regfile write address
//  o_ir_wdata    out  DATA_WIDTH  IR regfile write data
//  i_ir_ready    in   1           IR regfile accepts write this cycle
//  o_busy        out  1           high in every state except IDLE
//  o_done        out  1           1-cycle pulse on transfer completion
// BEHAVIOUR
//  - Reset: state=IDLE; src, dst, remaining, wdata regs = 0; all outputs 0.
//  - Registered Moore FSM; all outputs are functions of state and regs only.
//  - IDLE: init (macro) has priority over start; start -> RD_SRC.
//  - RD_SRC/RD_DST/RD_CNT: one cycle each, o_param_req=1, i_param_data latched
//    into src/dst/remaining at cycle end. After RD_CNT: remaining==0 -> DONE,
//    else CASH_RD.
//  - CASH_RD: o_cash_ren=1, o_cash_addr=src, 1 cycle -> WAIT.
//  - WAIT: RD_LAT cycles (internal latency counter); on the last cycle
//    i_cash_data is captured into the wdata reg -> IR_WR.
//  - IR_WR: o_ir_wen=1, o_ir_addr=dst, o_ir_wdata=wdata; hold all three stable
//    while i_ir_ready=0. On ready: src++, dst++, remaining--; if remaining was 1
//    -> DONE, else -> CASH_RD. Throughput = RD_LAT+2 cycles/word at ready=1.
//  - DONE: o_done=1 for exactly one cycle -> IDLE.
//  - Address arithmetic wraps modulo 2^ADDR_WIDTH, no error flag. Count is
//    unsigned; count=0 moves no words and still pulses o_done.
//  - i_abort: any non-IDLE state -> IDLE next cycle, no o_done, no write
//    commit in that cycle. Abort beats ready when both are high in IR_WR.
//  - i_start while busy is ignored (not queued).
//  - Reset mid-transfer: same as power-on reset, no done pulse.
// CONFIGURATION
//  IRL_INIT_EN defined: state INIT exists. i_init in IDLE -> INIT (1 cycle,
//    src=0, dst=0, remaining=INIT_LINES) -> CASH_RD, no descriptor fetch.
//  IRL_INIT_EN undefined: i_init port is still present but ignored; no INIT state.
// STRUCTURE
//  - ir_loader_pkg: state encodings (IDLE..DONE, INIT), RD_LAT counter width
//    function, default INIT_LINES constant.
//  - Sub-module ir_loader_ctr: loadable down-counter (load, dec, zero/one
//    flags), used for remaining and the WAIT latency count.
// TESTING
//  1 start, desc (src=8'h10, dst=8'h20, cnt=3), ready=1, RD_LAT=1 -> writes
//    dst 20,21,22 = cache[10..12]; o_done 1 cycle, 3+3*3+1 cycles after start.
//  2 cnt=0 -> no o_cash_ren, no o_ir_wen; o_done the cycle after RD_CNT.
//  3 cnt=2, ready held low 4 cycles on word 0 -> wen/addr/data stable all 4
//    cycles, one commit only, word 1 then proceeds.
//  4 src=8'hFE, dst=8'hFF, cnt=3 -> cache addrs FE,FF,00; IR addrs FF,00,01.
//  5 abort asserted in WAIT of word 1 of cnt=4 -> IDLE next cycle, no done,
//    exactly 1 write; new start then runs a full transfer cleanly.
//  6 IRL_INIT_EN, INIT_LINES=4, init+start same cycle -> INIT path wins,
//    no o_param_req, 4 writes cache[0..3] -> IR[0..3], done pulse.

Source files
------------

// File: rtl/ir_loader_pkg.sv
// Shared state encoding and helpers for the IR loader DMA.
// Defining IRL_INIT_EN adds the INIT preload state.
package ir_loader_pkg;

    localparam int INIT_LINES_DEF = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_SRC  = 4'd1,
        S_RD_DST  = 4'd2,
        S_RD_CNT  = 4'd3,
        S_CASH_RD = 4'd4,
        S_WAIT    = 4'd5,
        S_IR_WR   = 4'd6,
        S_DONE    = 4'd7
`ifdef IRL_INIT_EN
        , S_INIT  = 4'd8
`endif
    } state_t;

    // Bits needed to hold RD_LAT-1 (the WAIT countdown start value).
    function automatic int lat_cnt_w(input int rd_lat);
        return (rd_lat < 2) ? 1 : $clog2(rd_lat);
    endfunction

endpackage

// File: rtl/ir_loader_ctr.sv
// Loadable down-counter with zero/one flags; used for the word count
// and for the cache read-latency countdown.
module ir_loader_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == W'(1));

endmodule

// File: rtl/ir_loader_dma.sv
// Instruction loader: fetches a src/dst/count descriptor, then copies count
// words cache -> IR regfile. Optional init preload under IRL_INIT_EN.
module ir_loader_dma
    import ir_loader_pkg::*;
#(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   CNT_WIDTH  = 8,
    parameter int                   RD_LAT     = 1,
    parameter logic [CNT_WIDTH-1:0] INIT_LINES = CNT_WIDTH'(INIT_LINES_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_init,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_param_data,
    output logic                  o_param_req,
    output logic                  o_cash_ren,
    output logic [ADDR_WIDTH-1:0] o_cash_addr,
    input  logic [DATA_WIDTH-1:0] i_cash_data,
    output logic                  o_ir_wen,
    output logic [ADDR_WIDTH-1:0] o_ir_addr,
    output logic [DATA_WIDTH-1:0] o_ir_wdata,
    input  logic                  i_ir_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int LAT_W = lat_cnt_w(RD_LAT);

    state_t                state, nxt;
    logic [ADDR_WIDTH-1:0] src, dst;
    logic [DATA_WIDTH-1:0] wdata;
    logic [CNT_WIDTH-1:0]  rem_val;
    logic                  ld_src, ld_dst, ld_rem, clr_ptr;
    logic                  ld_lat, dec_lat, cap, commit;
    logic                  rem_one, lat_zero, desc_cnt_zero;
    logic                  unused_rem_zero, unused_lat_one;

    assign desc_cnt_zero = (i_param_data[CNT_WIDTH-1:0] == '0);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt     = state;
        ld_src  = 1'b0;
        ld_dst  = 1'b0;
        ld_rem  = 1'b0;
        rem_val = i_param_data[CNT_WIDTH-1:0];
        clr_ptr = 1'b0;
        ld_lat  = 1'b0;
        dec_lat = 1'b0;
        cap     = 1'b0;
        commit  = 1'b0;
        case (state)
            S_IDLE: begin
`ifdef IRL_INIT_EN
                if (i_init)
                    nxt = S_INIT;
                else if (i_start)
                    nxt = S_RD_SRC;
`else
                if (i_start)
                    nxt = S_RD_SRC;
`endif
            end
            S_RD_SRC: begin
                ld_src = 1'b1;
                nxt    = S_RD_DST;
            end
            S_RD_DST: begin
                ld_dst = 1'b1;
                nxt    = S_RD_CNT;
            end
            S_RD_CNT: begin
                ld_rem = 1'b1;
                nxt    = desc_cnt_zero ? S_DONE : S_CASH_RD;
            end
            S_CASH_RD: begin
                ld_lat = 1'b1;
                nxt    = S_WAIT;
            end
            S_WAIT: begin
                // Data is valid on the last WAIT cycle, RD_LAT after the read strobe.
                if (lat_zero) begin
                    cap = 1'b1;
                    nxt = S_IR_WR;
                end else begin
                    dec_lat = 1'b1;
                end
            end
            S_IR_WR: begin
                if (i_ir_ready) begin
                    commit = 1'b1;
                    nxt    = rem_one ? S_DONE : S_CASH_RD;
                end
            end
            S_DONE: nxt = S_IDLE;
`ifdef IRL_INIT_EN
            S_INIT: begin
                clr_ptr = 1'b1;
                ld_rem  = 1'b1;
                rem_val = INIT_LINES;
                nxt     = (INIT_LINES == '0) ? S_DONE : S_CASH_RD;
            end
`endif
            default: nxt = S_IDLE;
        endcase

        // Abort wins over everything, including a ready write in IR_WR.
        if (i_abort && state != S_IDLE) begin
            nxt     = S_IDLE;
            ld_src  = 1'b0;
            ld_dst  = 1'b0;
            ld_rem  = 1'b0;
            clr_ptr = 1'b0;
            ld_lat  = 1'b0;
            dec_lat = 1'b0;
            cap     = 1'b0;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src   <= '0;
            dst   <= '0;
            wdata <= '0;
        end else begin
            if (clr_ptr) begin
                src <= '0;
                dst <= '0;
            end else begin
                if (ld_src)
                    src <= i_param_data[ADDR_WIDTH-1:0];
                else if (commit)
                    src <= src + 1'b1;
                if (ld_dst)
                    dst <= i_param_data[ADDR_WIDTH-1:0];
                else if (commit)
                    dst <= dst + 1'b1;
            end
            if (cap)
                wdata <= i_cash_data;
        end
    end

    ir_loader_ctr #(.W(CNT_WIDTH)) u_rem (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld_rem),
        .load_val (rem_val),
        .dec      (commit),
        .zero     (unused_rem_zero),
        .one      (rem_one)
    );

    ir_loader_ctr #(.W(LAT_W)) u_lat (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld_lat),
        .load_val (LAT_W'(RD_LAT - 1)),
        .dec      (dec_lat),
        .zero     (lat_zero),
        .one      (unused_lat_one)
    );

`ifndef IRL_INIT_EN
    logic unused_cfg;
    assign unused_cfg = ^{i_init, INIT_LINES};
`endif

    assign o_param_req = (state == S_RD_SRC) || (state == S_RD_DST) || (state == S_RD_CNT);
    assign o_cash_ren  = (state == S_CASH_RD);
    assign o_cash_addr = src;
    assign o_ir_wen    = (state == S_IR_WR);
    assign o_ir_addr   = dst;
    assign o_ir_wdata  = wdata;
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);

endmodule

// File: tb/tb_ir_loader_dma.sv
// Self-checking bench for ir_loader_dma: event-queue reference model plus
// directed and randomized transfers.
module tb_ir_loader_dma;

    localparam int RD_LAT = 1;

    logic       clk, rst_n;
    logic       i_start, i_init, i_abort, i_ir_ready;
    logic [7:0] i_param_data, i_cash_data;
    logic       o_param_req, o_cash_ren, o_ir_wen, o_busy, o_done;
    logic [7:0] o_cash_addr, o_ir_addr, o_ir_wdata;

    ir_loader_dma #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(8),
        .RD_LAT(RD_LAT), .INIT_LINES(8'd4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_init(i_init),
        .i_abort(i_abort), .i_param_data(i_param_data),
        .o_param_req(o_param_req), .o_cash_ren(o_cash_ren),
        .o_cash_addr(o_cash_addr), .i_cash_data(i_cash_data),
        .o_ir_wen(o_ir_wen), .o_ir_addr(o_ir_addr), .o_ir_wdata(o_ir_wdata),
        .i_ir_ready(i_ir_ready), .o_busy(o_busy), .o_done(o_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int checks = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cache and descriptor sources
    logic [7:0] mem [256];
    logic [7:0] desc [3];
    int         pidx = 0;
    logic [7:0] cpipe [RD_LAT];

    always @(posedge clk) begin
        cpipe[0] <= o_cash_ren ? mem[o_cash_addr] : 8'($urandom);
        for (int i = 1; i < RD_LAT; i++) cpipe[i] <= cpipe[i-1];
        if (!rst_n) pidx <= 0;
        else if (o_param_req) pidx <= (pidx == 2) ? 0 : pidx + 1;
    end
    assign i_cash_data  = cpipe[RD_LAT-1];
    assign i_param_data = o_param_req ? desc[pidx] : 8'h5A;

    // Reference model: expected event queues
    logic [7:0]  exp_rd [$];
    logic [15:0] exp_wr [$];
    int          exp_done [$];
    int          exp_sbase [$];
    logic [7:0]  rd_log [$];
    logic [15:0] wr_log [$];
    int          n_preq = 0, n_wr = 0, stalls = 0, last_c0 = 0;
    bit          held = 0, done_q = 0;
    logic [7:0]  haddr, hdata;
    logic [15:0] cmp_e;

    // Ready driver: 0 = always ready, 1 = random, 2 = hold low for hold_left write cycles
    int rdy_mode = 0, hold_left = 0;
    initial begin
        i_ir_ready = 1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: i_ir_ready = 1'($urandom_range(0, 1));
                2: if (o_ir_wen && hold_left > 0) begin
                       i_ir_ready = 0;
                       hold_left--;
                   end else i_ir_ready = 1;
                default: i_ir_ready = 1;
            endcase
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (!rst_n) begin
            held   = 0;
            done_q = 0;
        end else begin
            if (o_param_req) begin
                n_preq++;
                chk("preq_busy", o_busy, 1);
            end
            if (o_cash_ren) begin
                rd_log.push_back(o_cash_addr);
                if (exp_rd.size() == 0) chk("unexp_ren", o_cash_ren, 0);
                else chk("cash_addr", o_cash_addr, exp_rd.pop_front());
            end
            if (o_ir_wen) begin
                if (held) begin
                    chk("hold_addr", o_ir_addr, haddr);
                    chk("hold_data", o_ir_wdata, hdata);
                end
                if (i_abort) held = 0;
                else if (i_ir_ready) begin
                    held = 0;
                    n_wr++;
                    wr_log.push_back({o_ir_addr, o_ir_wdata});
                    if (exp_wr.size() == 0) chk("unexp_wr", o_ir_wen, 0);
                    else begin
                        cmp_e = exp_wr.pop_front();
                        chk("ir_addr", o_ir_addr, cmp_e[15:8]);
                        chk("ir_wdata", o_ir_wdata, cmp_e[7:0]);
                    end
                end else begin
                    held  = 1;
                    haddr = o_ir_addr;
                    hdata = o_ir_wdata;
                    stalls++;
                end
            end else if (held) begin
                chk("wen_dropped", o_ir_wen, 1);
                held = 0;
            end
            if (o_done) begin
                if (exp_done.size() == 0) chk("unexp_done", o_done, 0);
                else chk("done_cyc", cyc, exp_done.pop_front() + (stalls - exp_sbase.pop_front()));
                chk("done_wr_left", exp_wr.size(), 0);
            end
            if (done_q) chk("busy_after_done", o_busy, 0);
            done_q = o_done;
        end
    end

    task automatic flush();
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        exp_sbase.delete();
    endtask

    task automatic expect_words(input logic [7:0] s, input logic [7:0] d, input int c, input int pre);
        logic [7:0] a, b;
        for (int k = 0; k < c; k++) begin
            a = s + 8'(k);
            b = d + 8'(k);
            exp_rd.push_back(a);
            exp_wr.push_back({b, mem[a]});
        end
        exp_done.push_back(last_c0 + pre + c * (RD_LAT + 2));
        exp_sbase.push_back(stalls);
    endtask

    task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] c, input bit hold);
        desc[0] = s; desc[1] = d; desc[2] = c;
        rd_log.delete();
        wr_log.delete();
        @(posedge clk); #1;
        last_c0 = cyc;
        expect_words(s, d, int'(c), 4);
        i_start = 1;
        if (!hold) begin
            @(posedge clk); #1;
            i_start = 0;
        end
    endtask

    task automatic wait_done(output int dly);
        int n;
        for (n = 0; n < 3000; n++) begin
            if (o_done) break;
            @(posedge clk); #1;
        end
        if (n == 3000) begin
            chk("timeout", o_done, 1);
            flush();
            dly = -1;
        end else dly = cyc - last_c0;
        i_start = 0;
        @(posedge clk); #1;
    endtask

    int dly, b_preq, b_wr, b_st, k;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        rst_n = 0; i_start = 0; i_init = 0; i_abort = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_flags", {o_busy, o_done, o_cash_ren, o_ir_wen, o_param_req}, 0);
        chk("rst_buses", {o_cash_addr, o_ir_addr, o_ir_wdata}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // 1: basic 3-word transfer
        b_preq = n_preq;
        launch(8'h10, 8'h20, 8'd3, 0);
        wait_done(dly);
        chk("t1_latency", dly, 13);
        chk("t1_preq", n_preq - b_preq, 3);
        chk("t1_nwr", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            chk("t1_wr0", wr_log[0], {8'h20, mem[8'h10]});
            chk("t1_wr2", wr_log[2], {8'h22, mem[8'h12]});
        end

        // 2: zero count
        launch(8'h33, 8'h44, 8'd0, 0);
        wait_done(dly);
        chk("t2_latency", dly, 4);
        chk("t2_nrd", rd_log.size(), 0);
        chk("t2_nwr", wr_log.size(), 0);

        // 3: backpressure on word 0
        b_st = stalls;
        rdy_mode = 2; hold_left = 4;
        launch(8'h30, 8'h40, 8'd2, 0);
        wait_done(dly);
        rdy_mode = 0;
        chk("t3_stalls", stalls - b_st, 4);
        chk("t3_latency", dly, 14);
        chk("t3_nwr", wr_log.size(), 2);

        // 4: address wrap
        launch(8'hFE, 8'hFF, 8'd3, 0);
        wait_done(dly);
        if (rd_log.size() == 3 && wr_log.size() == 3) begin
            chk("t4_rd2", rd_log[2], 8'h00);
            chk("t4_wr1", wr_log[1][15:8], 8'h00);
            chk("t4_wr2", wr_log[2][15:8], 8'h01);
        end else chk("t4_count", rd_log.size() + wr_log.size(), 6);

        // 5: abort in WAIT of word 1
        b_wr = n_wr;
        launch(8'h50, 8'h60, 8'd4, 0);
        k = 0;
        for (int n = 0; n < 200; n++) begin
            if (o_cash_ren) k++;
            else if (k == 2) break;
            @(posedge clk); #1;
        end
        i_abort = 1;
        @(posedge clk); #1;
        i_abort = 0;
        chk("t5_busy", o_busy, 0);
        chk("t5_nwr", n_wr - b_wr, 1);
        chk("t5_rd_left", exp_rd.size(), 2);
        flush();
        repeat (5) @(posedge clk); #1;
        launch(8'h70, 8'h80, 8'd3, 0);
        wait_done(dly);
        chk("t5_rerun_latency", dly, 13);

        // 5b: abort beats ready in IR_WR
        b_wr = n_wr;
        launch(8'h90, 8'hA0, 8'd2, 0);
        for (int n = 0; n < 200 && !o_ir_wen; n++) begin
            @(posedge clk); #1;
        end
        i_abort = 1;
        @(posedge clk); #1;
        i_abort = 0;
        chk("t5b_nwr", n_wr - b_wr, 0);
        flush();
        repeat (3) @(posedge clk); #1;

        // Reset mid-transfer
        launch(8'hB0, 8'hC0, 8'd5, 0);
        repeat (6) @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        chk("mrst_flags", {o_busy, o_done, o_cash_ren, o_ir_wen}, 0);
        flush();
        rst_n = 1;
        repeat (10) @(posedge clk); #1;

`ifdef IRL_INIT_EN
        // 6: init preload wins over start
        b_preq = n_preq;
        rd_log.delete();
        wr_log.delete();
        desc[0] = 8'h11; desc[1] = 8'h22; desc[2] = 8'd2;
        @(posedge clk); #1;
        last_c0 = cyc;
        expect_words(8'h00, 8'h00, 4, 2);
        i_start = 1; i_init = 1;
        @(posedge clk); #1;
        i_start = 0; i_init = 0;
        wait_done(dly);
        chk("t6_latency", dly, 14);
        chk("t6_preq", n_preq - b_preq, 0);
        chk("t6_nwr", wr_log.size(), 4);
`endif

        // Randomized transfers: random ready, start sometimes held through busy
        for (int it = 0; it < 25; it++) begin
            logic [7:0] s, d, c;
            s = 8'($urandom);
            d = 8'($urandom);
            c = 8'($urandom_range(0, 6));
            rdy_mode = int'($urandom_range(0, 1));
            launch(s, d, c, 1'($urandom_range(0, 1)));
            wait_done(dly);
            chk("rnd_nwr", wr_log.size(), int'(c));
        end
        rdy_mode = 0;

        repeat (5) @(posedge clk); #1;
        chk("end_queues", exp_rd.size() + exp_wr.size() + exp_done.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
